// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC execute-side definitions.
//   DATA_W    : datapath width (ALU result, writeback data, branch target)
//   REG_AW    : register index width (r0 hard-wired to zero)
//   br_cond_e : branch condition encodings carried on in_br_cond
package kgp_risc_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [2:0] {
        BR_NONE   = 3'b000,
        BR_ALWAYS = 3'b001,
        BR_Z      = 3'b010,
        BR_NZ     = 3'b011,
        BR_LTZ    = 3'b100,
        BR_CY     = 3'b101,
        BR_NCY    = 3'b110,
        BR_RSVD   = 3'b111
    } br_cond_e;

endpackage

// File: rtl/alu_result_stage_wb_fifo2.sv
// wb_fifo2: two-entry in-order FIFO of {data, rd} writeback records.
//   clk, rst             : clock, synchronous active-high reset
//   push, push_data/rd   : enqueue request and record (ignored when full)
//   pop                  : dequeue request (ignored when empty)
//   count                : occupancy 0..2
//   head_data, head_rd   : oldest entry; slot 0 is always the head
module wb_fifo2 #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [AW-1:0] push_rd,
    input  logic          pop,
    output logic [1:0]    count,
    output logic [DW-1:0] head_data,
    output logic [AW-1:0] head_rd
);

    logic [DW-1:0] data0, data1;
    logic [AW-1:0] rd0, rd1;
    logic          do_push, do_pop;

    assign do_push   = push && (count != 2'd2);
    assign do_pop    = pop  && (count != 2'd0);
    assign head_data = data0;
    assign head_rd   = rd0;

    // Shift-style storage: a pop moves slot 1 into slot 0, so the head
    // never needs a read pointer and stays stable while not popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            data0 <= '0;
            rd0   <= '0;
            data1 <= '0;
            rd1   <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        data0 <= push_data;
                        rd0   <= push_rd;
                    end else begin
                        data1 <= push_data;
                        rd1   <= push_rd;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    data0 <= data1;
                    rd0   <= rd1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        data0 <= push_data;
                        rd0   <= push_rd;
                    end else begin
                        data0 <= data1;
                        rd0   <= rd1;
                        data1 <= push_data;
                        rd1   <= push_rd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: execute-side stage after the KGP-RISC ALU.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : ALU handshake; in_ready depends on registered state only
//   in_result, in_f*      : ALU result and zero/sign/carry outputs
//   in_flag_we            : load architectural flags on accept
//   in_rd, in_rd_we       : writeback destination (r0 writes dropped)
//   in_br_cond/target     : branch condition code and target
//   wb_valid/ready/data/rd: head of the 2-entry writeback buffer
//   flag_zero/sign/carry  : architectural flags
//   br_taken, br_target   : one-cycle branch pulse, cycle after accept
import kgp_risc_pkg::*;

module alu_result_stage #(
    parameter int unsigned DATA_W = kgp_risc_pkg::DATA_W,
    parameter int unsigned REG_AW = kgp_risc_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_fzero,
    input  logic              in_fsign,
    input  logic              in_fcarry,
    input  logic              in_flag_we,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic [2:0]        in_br_cond,
    input  logic [DATA_W-1:0] in_br_target,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_AW-1:0] wb_rd,
    output logic              flag_zero,
    output logic              flag_sign,
    output logic              flag_carry,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target
);

    logic       rst_q;
    logic [1:0] count;
    logic       accept;
    logic       cond_true;
    logic       wb_push;
    logic       wb_pop;

    // Holding off in_ready for one cycle after reset keeps the handshake
    // purely register-driven, with no path from rst or wb_ready.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    assign in_ready = !rst_q && (count != 2'd2);
    assign accept   = in_valid && in_ready;
    assign wb_push  = accept && in_rd_we && (in_rd != '0);
    assign wb_valid = (count != 2'd0);
    assign wb_pop   = wb_valid && wb_ready;

    // Carry conditions read flag_carry before this cycle's flag update.
    always_comb begin
        cond_true = 1'b0;
        case (br_cond_e'(in_br_cond))
            BR_ALWAYS: cond_true = 1'b1;
            BR_Z:      cond_true = (in_result == '0);
            BR_NZ:     cond_true = (in_result != '0);
            BR_LTZ:    cond_true = in_result[DATA_W-1];
            BR_CY:     cond_true = flag_carry;
            BR_NCY:    cond_true = !flag_carry;
            default:   cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_zero  <= 1'b0;
            flag_sign  <= 1'b0;
            flag_carry <= 1'b0;
            br_taken   <= 1'b0;
            br_target  <= '0;
        end else begin
            if (accept && in_flag_we) begin
                flag_zero  <= in_fzero;
                flag_sign  <= in_fsign;
                flag_carry <= in_fcarry;
            end
            br_taken <= accept && cond_true;
            if (accept && cond_true) begin
                br_target <= in_br_target;
            end
        end
    end

    wb_fifo2 #(
        .DW (DATA_W),
        .AW (REG_AW)
    ) u_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wb_push),
        .push_data (in_result),
        .push_rd   (in_rd),
        .pop       (wb_pop),
        .count     (count),
        .head_data (wb_data),
        .head_rd   (wb_rd)
    );

endmodule
